// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM port
// between instruction fetch and load/store data.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CW = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic              r_last_d, w_last_d_n;
  logic              r_own_d, w_own_d_n;
  logic              r_we, w_we_n;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata_n;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_n;
  logic              r_i_ready, w_i_ready_n;
  logic              r_d_ready, w_d_ready_n;
  logic              r_ram_en, w_ram_en_n;
  logic              r_ram_we, w_ram_we_n;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_n;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_n;
  logic              r_busy, w_busy_n;
  logic              w_d_req, w_gnt_i, w_gnt_d;

  assign w_d_req = d_read | d_write;

  // On conflict the port that did not win last time goes first
  assign w_gnt_i = i_req & (~w_d_req | r_last_d);
  assign w_gnt_d = w_d_req & (~i_req | ~r_last_d);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
      r_own_d     <= 1'b0;
      r_we        <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_last_d    <= w_last_d_n;
      r_own_d     <= w_own_d_n;
      r_we        <= w_we_n;
      r_i_rdata   <= w_i_rdata_n;
      r_d_rdata   <= w_d_rdata_n;
      r_i_ready   <= w_i_ready_n;
      r_d_ready   <= w_d_ready_n;
      r_ram_en    <= w_ram_en_n;
      r_ram_we    <= w_ram_we_n;
      r_ram_addr  <= w_ram_addr_n;
      r_ram_wdata <= w_ram_wdata_n;
      r_busy      <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_last_d_n    = r_last_d;
    w_own_d_n     = r_own_d;
    w_we_n        = r_we;
    w_i_rdata_n   = r_i_rdata;
    w_d_rdata_n   = r_d_rdata;
    w_i_ready_n   = 1'b0;
    w_d_ready_n   = 1'b0;
    w_ram_en_n    = 1'b0;
    w_ram_we_n    = 1'b0;
    w_ram_addr_n  = r_ram_addr;
    w_ram_wdata_n = r_ram_wdata;
    w_busy_n      = r_busy;
    unique case (r_state)
      IDLE: begin
        w_busy_n = 1'b0;
        if (w_gnt_i | w_gnt_d) begin
          w_state_n    = ACCESS;
          w_cnt_n      = CW'(RAM_LAT - 1);
          w_own_d_n    = w_gnt_d;
          w_last_d_n   = w_gnt_d;
          w_we_n       = w_gnt_d & d_write;
          w_ram_addr_n = w_gnt_d ? d_addr : i_addr;
          if (w_gnt_d)
            w_ram_wdata_n = d_wdata;
          w_ram_en_n   = 1'b1;
          w_ram_we_n   = w_gnt_d & d_write;
          w_busy_n     = 1'b1;
        end
      end
      ACCESS: begin
        w_busy_n = 1'b1;
        if (r_cnt == '0) begin
          w_state_n = DONE;
          if (r_own_d) begin
            w_d_ready_n = 1'b1;
            if (!r_we)
              w_d_rdata_n = ram_rdata;
          end else begin
            w_i_ready_n = 1'b1;
            w_i_rdata_n = ram_rdata;
          end
        end else begin
          w_cnt_n    = r_cnt - CW'(1);
          w_ram_en_n = 1'b1;
          w_ram_we_n = r_we;
        end
      end
      DONE: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  assign i_rdata   = r_i_rdata;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM_LAT=2 instance
// with a small RAM model, plus a RAM_LAT=1 instance.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        i_req, d_read, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        i_ready, d_ready, ram_en, ram_we, busy;

  logic        i_req2;
  logic [31:0] i_addr2, i_rdata2, d_rdata2, ram_addr2, ram_wdata2, ram_rdata2;
  logic        i_ready2, d_ready2, ram_en2, ram_we2, busy2;
  logic        z1;
  logic [31:0] z32;

  logic [31:0] mem [0:255];
  int checks, errors;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) dut2 (
    .clock(clock), .reset(reset),
    .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_ready(i_ready2),
    .d_read(z1), .d_write(z1), .d_addr(z32), .d_wdata(z32),
    .d_rdata(d_rdata2), .d_ready(d_ready2),
    .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2),
    .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2), .busy(busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_rdata  = (ram_addr == 32'h100) ? 32'hDEADBEEF : mem[ram_addr[9:2]];
  assign ram_rdata2 = ram_addr2 ^ 32'hFFFF0000;

  always @(posedge clock)
    if (ram_en && ram_we) mem[ram_addr[9:2]] <= ram_wdata;

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({ram_en, ram_we, i_ready, d_ready, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {ram_en, ram_we, i_ready, d_ready, busy});
    end
    checks++;
    if ({i_rdata, d_rdata, ram_addr, ram_wdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {i_rdata, d_rdata, ram_addr, ram_wdata});
    end
    checks++;
    if ({ram_en2, i_ready2, busy2} !== 3'b0) begin
      errors++;
      $display("FAIL reset_dut2 got %b exp 000", {ram_en2, i_ready2, busy2});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    i_addr = 32'h100;
    i_req  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en, ram_we, i_ready, d_ready, busy} !== {(k <= 2), 1'b0, (k == 3), 1'b0, (k <= 3)}) begin
        errors++;
        $display("FAIL fetch_c%0d en/we/ir/dr/busy got %b exp %b", k,
          {ram_en, ram_we, i_ready, d_ready, busy}, {(k <= 2), 1'b0, (k == 3), 1'b0, (k <= 3)});
      end
      if (k <= 2) begin
        checks++;
        if (ram_addr !== 32'h100) begin
          errors++;
          $display("FAIL fetch_addr got %h exp 00000100", ram_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL fetch_rdata got %h exp deadbeef", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    d_addr  = 32'h200;
    d_wdata = 32'h12345678;
    d_write = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en, ram_we, d_ready, i_ready} !== {(k <= 2), (k <= 2), (k == 3), 1'b0}) begin
        errors++;
        $display("FAIL write_c%0d en/we/dr/ir got %b exp %b", k,
          {ram_en, ram_we, d_ready, i_ready}, {(k <= 2), (k <= 2), (k == 3), 1'b0});
      end
      if (k <= 2) begin
        checks++;
        if ({ram_addr, ram_wdata} !== {32'h200, 32'h12345678}) begin
          errors++;
          $display("FAIL write_bus got %h exp 0000020012345678", {ram_addr, ram_wdata});
        end
      end
      if (k == 3) d_write = 1'b0;
    end
    d_read = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en, ram_we, d_ready} !== {(k <= 2), 1'b0, (k == 3)}) begin
        errors++;
        $display("FAIL read_c%0d en/we/dr got %b exp %b", k,
          {ram_en, ram_we, d_ready}, {(k <= 2), 1'b0, (k == 3)});
      end
      if (k == 3) begin
        checks++;
        if (d_rdata !== 32'h12345678) begin
          errors++;
          $display("FAIL read_rdata got %h exp 12345678", d_rdata);
        end
        d_read = 1'b0;
      end
    end
  endtask

  task automatic test_conflict();
    reset  = 1'b1;
    i_addr = 32'h100;
    d_addr = 32'h200;
    i_req  = 1'b1;
    d_read = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en, i_ready, d_ready} !==
          {(k % 4 == 1 || k % 4 == 2), (k == 3 || k == 11), (k == 7 || k == 15)}) begin
        errors++;
        $display("FAIL conflict_c%0d en/ir/dr got %b exp %b", k, {ram_en, i_ready, d_ready},
          {(k % 4 == 1 || k % 4 == 2), (k == 3 || k == 11), (k == 7 || k == 15)});
      end
      if (k % 4 == 1) begin
        checks++;
        if (ram_addr !== (((k / 4) % 2 == 0) ? 32'h100 : 32'h200)) begin
          errors++;
          $display("FAIL conflict_grant_c%0d addr got %h", k, ram_addr);
        end
      end
      if (k == 3 || k == 11) begin
        checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL conflict_irdata got %h exp deadbeef", i_rdata);
        end
      end
      if (k == 7 || k == 15) begin
        checks++;
        if (d_rdata !== 32'h12345678) begin
          errors++;
          $display("FAIL conflict_drdata got %h exp 12345678", d_rdata);
        end
      end
      if (k == 15) begin
        i_req  = 1'b0;
        d_read = 1'b0;
      end
    end
  endtask

  task automatic test_rw_both();
    d_addr  = 32'h40;
    d_wdata = 32'hA5A5A5A5;
    d_read  = 1'b1;
    d_write = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en, ram_we, d_ready} !== {(k <= 2), (k <= 2), (k == 3)}) begin
        errors++;
        $display("FAIL rwboth_c%0d en/we/dr got %b exp %b", k,
          {ram_en, ram_we, d_ready}, {(k <= 2), (k <= 2), (k == 3)});
      end
      checks++;
      if (d_rdata !== 32'h12345678) begin
        errors++;
        $display("FAIL rwboth_rdata_c%0d got %h exp 12345678", k, d_rdata);
      end
      if (k == 3) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    checks++;
    if (mem[16] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rwboth_mem got %h exp a5a5a5a5", mem[16]);
    end
  endtask

  task automatic test_reset_mid();
    i_addr = 32'h100;
    i_req  = 1'b1;
    @(negedge clock);
    checks++;
    if (ram_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre en got %b exp 1", ram_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ram_en, ram_we, busy, i_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_async got %b exp 0000", {ram_en, ram_we, busy, i_ready});
    end
    @(negedge clock);
    checks++;
    if ({ram_en, i_ready, d_ready} !== 3'b0) begin
      errors++;
      $display("FAIL rstmid_hold got %b exp 000", {ram_en, i_ready, d_ready});
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en, i_ready, d_ready} !== {(k <= 2), (k == 3), 1'b0}) begin
        errors++;
        $display("FAIL rstmid_c%0d en/ir/dr got %b exp %b", k,
          {ram_en, i_ready, d_ready}, {(k <= 2), (k == 3), 1'b0});
      end
      if (k == 3) begin
        checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rstmid_rdata got %h exp deadbeef", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_lat1();
    i_addr2 = 32'h300;
    i_req2  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      checks++;
      if ({ram_en2, i_ready2, busy2} !== {(k % 3 == 1), (k % 3 == 2), (k % 3 != 0)}) begin
        errors++;
        $display("FAIL lat1_c%0d en/ir/busy got %b exp %b", k,
          {ram_en2, i_ready2, busy2}, {(k % 3 == 1), (k % 3 == 2), (k % 3 != 0)});
      end
      if (k % 3 == 2) begin
        checks++;
        if (i_rdata2 !== 32'hFFFF0300) begin
          errors++;
          $display("FAIL lat1_rdata got %h exp ffff0300", i_rdata2);
        end
      end
    end
    i_req2 = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    i_req   = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    i_req2  = 1'b0;
    i_addr2 = '0;
    z1      = 1'b0;
    z32     = '0;
    test_reset();
    test_fetch();
    test_write_read();
    test_conflict();
    test_rw_both();
    test_reset_mid();
    test_lat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
